// File: rtl/gshare_predictor_pkg.sv
// gshare_predictor_pkg: counter encodings, index modes, sequencer states and
// the 2-bit saturating counter step shared by the predictor files.
package gshare_predictor_pkg;
    typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} ctr_t;
    typedef enum logic {CLEAR, RUN} state_t;
    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE = 1;
    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        return taken ? ((c == ST) ? c : c + 2'd1) : ((c == SNT) ? c : c - 2'd1);
    endfunction
endpackage

// File: rtl/gshare_predictor_if.sv
// gshare_predictor_if: prediction, feedback, control and statistics signals
// between the pipeline (master) and the predictor (slave).
interface gshare_predictor_if #(parameter int HIST = 8, parameter int CNT_W = 32);
    logic flush, ready, bp_oe, bp_taken, fb_we, fb_taken, stat_clr;
    logic [31:0] bp_pc, fb_pc;
    logic [HIST+1:0] bp_meta, fb_meta;
    logic [CNT_W-1:0] cnt_pred, cnt_hit;
    modport master(
        output flush, bp_pc, bp_oe, fb_pc, fb_we, fb_taken, fb_meta, stat_clr,
        input ready, bp_taken, bp_meta, cnt_pred, cnt_hit
    );
    modport slave(
        input flush, bp_pc, bp_oe, fb_pc, fb_we, fb_taken, fb_meta, stat_clr,
        output ready, bp_taken, bp_meta, cnt_pred, cnt_hit
    );
endinterface

// File: rtl/gshare_predictor_pht_ram.sv
// gshare_predictor_pht_ram: simple dual-port 2-bit PHT, registered read with
// enable, read-before-write on collision, no reset (cleared by the sequencer).
module gshare_predictor_pht_ram #(parameter int SCALE = 10) (
    input  logic             clk,
    input  logic             oe,
    input  logic [SCALE-1:0] raddr,
    output logic [1:0]       rdata,
    input  logic             we,
    input  logic [SCALE-1:0] waddr,
    input  logic [1:0]       wdata
);
    logic [1:0] mem [2**SCALE];
    always_ff @(posedge clk) begin
        if (oe) rdata <= mem[raddr];
        if (we) mem[waddr] <= wdata;
    end
endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: bimodal/gshare direction predictor with a table-clear
// sequencer, non-speculative global history and hit statistics.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int SCALE = 10,
    parameter int HIST  = 8,
    parameter int MODE  = 1,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst,
    gshare_predictor_if.slave bp
);
    state_t state;
    logic [SCALE-1:0] clr_idx, ridx, uidx, waddr;
    logic [HIST-1:0] ghr, ghr_snap;
    logic [1:0] rdata, wdata;
    logic run, accept, we, vld, unused_ok;
    // flush wins over everything else in the cycle it arrives
    assign run = state == RUN && !bp.flush;
    assign accept = run && bp.fb_we;
    assign ridx = bp.bp_pc[2+:SCALE] ^ (MODE == MODE_GSHARE ? SCALE'(ghr) : '0);
    assign uidx = bp.fb_pc[2+:SCALE] ^ (MODE == MODE_GSHARE ? SCALE'(bp.fb_meta[HIST+1:2]) : '0);
    assign we = state == CLEAR || accept;
    assign waddr = state == CLEAR ? clr_idx : uidx;
    assign wdata = state == CLEAR ? 2'(WNT) : ctr_next(bp.fb_meta[1:0], bp.fb_taken);
    assign bp.bp_taken = vld & rdata[1];
    assign bp.bp_meta = vld ? {ghr_snap, rdata} : '0;
    assign unused_ok = ^{bp.bp_pc, bp.fb_pc, bp.fb_meta};
    gshare_predictor_pht_ram #(.SCALE(SCALE)) pht_ram (
        .clk(clk), .oe(bp.bp_oe && run), .raddr(ridx), .rdata(rdata),
        .we(we), .waddr(waddr), .wdata(wdata)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            clr_idx <= '0;
            ghr <= '0;
            bp.ready <= 1'b0;
        end else if (bp.flush) begin
            state <= CLEAR;
            clr_idx <= '0;
            ghr <= '0;
            bp.ready <= 1'b0;
        end else if (state == CLEAR) begin
            clr_idx <= clr_idx + SCALE'(1);
            if (&clr_idx) begin
                state <= RUN;
                bp.ready <= 1'b1;
            end
        end else if (bp.fb_we) begin
            ghr <= HIST'({ghr, bp.fb_taken});
        end
    end
    // vld masks the unreset RAM output until a read completes in RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
            ghr_snap <= '0;
        end else if (!run) begin
            vld <= 1'b0;
        end else if (bp.bp_oe) begin
            vld <= 1'b1;
            ghr_snap <= ghr;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp.cnt_pred <= '0;
            bp.cnt_hit <= '0;
        end else if (bp.stat_clr) begin
            bp.cnt_pred <= '0;
            bp.cnt_hit <= '0;
        end else if (accept) begin
            bp.cnt_pred <= bp.cnt_pred + CNT_W'(1);
            bp.cnt_hit <= bp.cnt_hit + CNT_W'(bp.fb_taken == bp.fb_meta[1]);
        end
    end
endmodule
